// File: rtl/div3_seq.sv
// Sequential divisible-by-3 checker: repeatedly folds the operand with the
// alternating-bit-sum rule until the residue drops below 3, then reports.
module div3_seq #(
  parameter int DATA_W = 8,
  parameter int ITER_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_div,
  output logic [ITER_W-1:0] out_iters,
  output logic [CNT_W-1:0]  div_cnt
);

  localparam int NE   = (DATA_W + 1) / 2;
  localparam int NO   = DATA_W / 2;
  localparam int PC_W = $clog2(DATA_W / 2 + 1) + 1;

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] res_reg;
  logic [ITER_W-1:0] iters_reg;
  logic              div_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [NE-1:0]     even_bits;
  logic [NO-1:0]     odd_bits;
  logic [PC_W-1:0]   e_cnt, o_cnt, diff;
  logic [DATA_W-1:0] res_step;
  logic              res_lt3;

  // Split the residue into even- and odd-position bits.
  genvar gi;
  generate
    for (gi = 0; gi < NE; gi++) begin : g_even
      assign even_bits[gi] = res_reg[2*gi];
    end
    for (gi = 0; gi < NO; gi++) begin : g_odd
      assign odd_bits[gi] = res_reg[2*gi+1];
    end
  endgenerate

  always_comb begin
    e_cnt = '0;
    o_cnt = '0;
    for (int i = 0; i < NE; i++) e_cnt = e_cnt + PC_W'(even_bits[i]);
    for (int i = 0; i < NO; i++) o_cnt = o_cnt + PC_W'(odd_bits[i]);
    diff     = (e_cnt >= o_cnt) ? (e_cnt - o_cnt) : (o_cnt - e_cnt);
    res_step = DATA_W'(diff);
    res_lt3  = (res_reg < DATA_W'(3));
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = REDUCE;
      REDUCE:  if (res_lt3)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_reg   <= '0;
      iters_reg <= '0;
      div_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            res_reg   <= in_data;
            iters_reg <= '0;
          end
        end
        REDUCE: begin
          if (res_lt3) begin
            div_reg <= (res_reg == '0);
          end else begin
            res_reg <= res_step;
            if (!(&iters_reg)) iters_reg <= iters_reg + 1'b1;
          end
        end
        DONE: begin
          // Statistics count only results actually taken by the consumer.
          if (out_ready && div_reg && !(&cnt_reg)) cnt_reg <= cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_div   = div_reg;
  assign out_iters = iters_reg;
  assign div_cnt   = cnt_reg;

endmodule

// File: tb/tb_div3_seq.sv
// Bench for div3_seq: vector table plus backpressure, reset and saturation
// sequences; expected results travel through a scoreboard queue.
module tb_div3_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_div;
  logic [3:0] out_iters;
  logic [7:0] div_cnt;

  typedef struct {
    logic [7:0] data;
    logic       div;
    logic [3:0] iters;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       div;
    logic [3:0] iters;
    int         lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   model_cnt = 0;

  div3_seq #(.DATA_W(8), .ITER_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_div(out_div), .out_iters(out_iters), .div_cnt(div_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Present an operand and let it be accepted on the next edge.
  task automatic start_op(input logic [7:0] d, input logic ediv, input logic [3:0] eit);
    exp_t x;
    in_data  = d;
    in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    x.data = d; x.div = ediv; x.iters = eit; x.lat = int'(eit) + 2;
    sb.push_back(x);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result, optionally stall it, then hand it off.
  task automatic wait_result(input int hold, input logic stray_in);
    exp_t x;
    int   lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 32'(out_valid), 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    x = sb.pop_front();
    chk("out_div", 32'(out_div), 32'(x.div));
    chk("out_iters", 32'(out_iters), 32'(x.iters));
    chk("latency", 32'(lat), 32'(x.lat));
    if (stray_in) begin
      in_data  = 8'h03;
      in_valid = 1'b1;
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_div", 32'(out_div), 32'(x.div));
      chk("hold_out_iters", 32'(out_iters), 32'(x.iters));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (x.div && model_cnt < 255) model_cnt++;
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("div_cnt", 32'(div_cnt), 32'(model_cnt));
    $display("op data=%02h div=%0d iters=%0d lat=%0d div_cnt=%0d",
             x.data, x.div, x.iters, lat, div_cnt);
  endtask

  initial begin
    vecs[0]  = '{8'h00, 1'b1, 4'd0};
    vecs[1]  = '{8'hFF, 1'b1, 4'd1};
    vecs[2]  = '{8'h15, 1'b1, 4'd2};
    vecs[3]  = '{8'h07, 1'b0, 4'd1};
    vecs[4]  = '{8'h05, 1'b0, 4'd1};
    vecs[5]  = '{8'h03, 1'b1, 4'd1};
    vecs[6]  = '{8'h02, 1'b0, 4'd0};
    vecs[7]  = '{8'h01, 1'b0, 4'd0};
    vecs[8]  = '{8'hAA, 1'b0, 4'd2};
    vecs[9]  = '{8'h3F, 1'b1, 4'd1};
    vecs[10] = '{8'h96, 1'b1, 4'd1};
    vecs[11] = '{8'hB6, 1'b0, 4'd1};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_div", 32'(out_div), 32'd0);
    chk("reset_out_iters", 32'(out_iters), 32'd0);
    chk("reset_div_cnt", 32'(div_cnt), 32'd0);

    foreach (vecs[i]) begin
      start_op(vecs[i].data, vecs[i].div, vecs[i].iters);
      wait_result(0, 1'b0);
    end

    // Backpressure with a competing operand held on the input.
    start_op(8'h15, 1'b1, 4'd2);
    wait_result(5, 1'b1);
    chk("stray_not_taken_in_done", 32'(in_valid), 32'd1);
    start_op(8'h03, 1'b1, 4'd1);
    chk("stray_accepted_after_hs", 32'(in_ready), 32'd0);
    wait_result(0, 1'b0);

    // Reset while reducing discards the operand and clears statistics.
    in_data  = 8'h15;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_reduce_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_cnt = 0;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_div_cnt", 32'(div_cnt), 32'd0);
    chk("rst_mid_out_iters", 32'(out_iters), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_mid_stays_idle", 32'(out_valid), 32'd0);
    end

    // Saturation of the divisible-result counter.
    for (int n = 0; n < 257; n++) begin
      start_op(8'h00, 1'b1, 4'd0);
      wait_result(0, 1'b0);
    end
    chk("div_cnt_saturated", 32'(div_cnt), 32'd255);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
